// File: rtl/iter_div_if.sv
// Operand/result bundle for the iterative divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface iter_div_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, src1, src2, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // The divider itself.
    modport slave (
        input  in_valid, src1, src2, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iter_div.sv
// Radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Latency: accept in cycle 0, result valid in cycle WIDTH+1, fixed for all operands.
// Backpressure: result held in DONE until out_ready; no new operands accepted until then.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    iter_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;      // partial remainder; always < divisor so WIDTH bits suffice
    logic [WIDTH-1:0] r_dvd;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic             r_neg_dvd;  // signed mode and dividend negative
    logic             r_neg_q;    // signed mode and operand signs differ
    logic             r_zero;

    logic [WIDTH-1:0] r_quo_o;
    logic [WIDTH-1:0] r_rem_o;
    logic             r_dbz_o;

    // Operand magnitudes at accept time.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;

    // One restoring step: the shifted remainder is WIDTH+1 bits wide so a
    // divisor magnitude of 2^(WIDTH-1) still compares correctly.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_last;

    assign w_a_neg   = bus.is_signed & bus.src1[WIDTH-1];
    assign w_b_neg   = bus.is_signed & bus.src2[WIDTH-1];
    assign w_a_abs   = w_a_neg ? (~bus.src1 + 1'b1) : bus.src1;
    assign w_b_abs   = w_b_neg ? (~bus.src2 + 1'b1) : bus.src2;

    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    // When w_ge holds the difference is below the divisor, so the top bit is zero.
    assign w_trial   = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // With a zero divisor every trial succeeds, so the remainder ends up as the
    // dividend magnitude; the sign correction then restores src1 exactly.
    assign w_quo_fix = r_zero  ? {WIDTH{1'b1}}
                     : r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fix = r_neg_dvd ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration, and result registration on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_neg_dvd <= 1'b0;
            r_neg_q   <= 1'b0;
            r_zero    <= 1'b0;
            r_quo_o   <= '0;
            r_rem_o   <= '0;
            r_dbz_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_neg_dvd <= w_a_neg;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_dvd     <= w_a_abs;
                        r_dvs     <= w_b_abs;
                        r_zero    <= (bus.src2 == '0);
                        r_rem     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quo_o <= w_quo_fix;
                        r_rem_o <= w_rem_fix;
                        r_dbz_o <= r_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.quotient    = r_quo_o;
    assign bus.remainder   = r_rem_o;
    assign bus.div_by_zero = r_dbz_o;
endmodule

// File: tb/tb_iter_div.sv
// Directed plus random bench for iter_div with a result scoreboard.
// Latency: checks result appears exactly WIDTH+1 cycles after accept.
// Backpressure: exercises out_ready stalls and mid-operation reset.
module tb_iter_div;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iter_div_if #(.WIDTH(W)) bus();
    iter_div #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the language's own division operators.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Wait for idle, present operands for one accept edge, record expectation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.src1      = a;
        bus.src2      = b;
        bus.is_signed = s;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    // Called in cycle 1 after accept; waits for the result and scores it.
    task automatic finish_op(input string tag);
        int   lat = 1;
        exp_t e;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, W + 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},   bus.quotient,  e.q);
            check({tag, "_r"},   bus.remainder, e.r);
            check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        end
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, "_in_ready_after"},  {31'd0, bus.in_ready},  32'd1);
            check({tag, "_out_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("rst_q",         bus.quotient,             32'd0);
        check("rst_r",         bus.remainder,            32'd0);
        check("rst_dbz",       {31'd0, bus.div_by_zero}, 32'd0);

        start_op(32'd100, 32'd7, 1'b0, '{32'd14, 32'd2, 1'b0});
        finish_op("u100_7");

        start_op(32'hFFFFFFF9, 32'd2, 1'b1, '{32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
        finish_op("s_m7_2");
        start_op(32'd7, 32'hFFFFFFFE, 1'b1, '{32'hFFFFFFFD, 32'd1, 1'b0});
        finish_op("s_7_m2");

        start_op(32'd5, 32'd0, 1'b1, '{32'hFFFFFFFF, 32'd5, 1'b1});
        finish_op("s_dbz5");
        start_op(32'd5, 32'd0, 1'b0, '{32'hFFFFFFFF, 32'd5, 1'b1});
        finish_op("u_dbz5");
        start_op(32'h80000000, 32'd0, 1'b1, '{32'hFFFFFFFF, 32'h80000000, 1'b1});
        finish_op("s_dbz_min");
        start_op(32'hFFFFFFF9, 32'd0, 1'b1, '{32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1});
        finish_op("s_dbz_m7");

        start_op(32'h80000000, 32'hFFFFFFFF, 1'b1, '{32'h80000000, 32'd0, 1'b0});
        finish_op("s_ovf");
        start_op(32'h80000000, 32'hFFFFFFFF, 1'b0, '{32'd0, 32'h80000000, 1'b0});
        finish_op("u_ovf_ops");

        // Backpressure: result held while new operands are offered and ignored.
        bus.out_ready = 1'b0;
        start_op(32'd1000, 32'd3, 1'b0, '{32'd333, 32'd1, 1'b0});
        bus.in_valid  = 1'b1;
        bus.src1      = 32'd77;
        bus.src2      = 32'd5;
        bus.is_signed = 1'b0;
        finish_op("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",    {31'd0, bus.out_valid},   32'd1);
            check("bp_hold_in_ready", {31'd0, bus.in_ready},    32'd0);
            check("bp_hold_q",        bus.quotient,             32'd333);
            check("bp_hold_r",        bus.remainder,            32'd1);
            check("bp_hold_dbz",      {31'd0, bus.div_by_zero}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_q_held",    bus.quotient,           32'd333);
        sb.push_back('{32'd15, 32'd2, 1'b0});
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_op("bp_next");

        // Reset during CALC when the iteration counter reads 10.
        start_op(32'hDEAD0000, 32'd3, 1'b0, model(32'hDEAD0000, 32'd3, 1'b0));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_in_ready",  {31'd0, bus.in_ready},    32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("abort_q",         bus.quotient,             32'd0);
        check("abort_r",         bus.remainder,            32'd0);
        check("abort_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
        start_op(32'hFFFFFFFF, 32'h10, 1'b0, '{32'h0FFFFFFF, 32'hF, 1'b0});
        finish_op("post_abort");

        // Random operands scored against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            s = i[0] ^ i[1];
            start_op(a, b, s, model(a, b, s));
            finish_op("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
